grf_wb_arbiter: RTL

- Shares the single GRF write port between two writeback sources.
  - Primary: the main pipeline WB stage.
  - Secondary: multi-cycle units such as mul/div, returning results out of order with the pipeline.
- Buffers secondary results in a small FIFO and arbitrates with anti-starvation.
- Keeps a per-register pending scoreboard so decode can stall on reads of registers with outstanding secondary writes.
- Sits between the WB stage, the mul/div unit and the GRF write port (we, wa, wd, pc).

---
 rtl/grf_wb_arbiter_if.sv | 51 +++++
 rtl/grf_wb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - bus bundle for the GRF writeback arbiter
interface grf_wb_arbiter_if;
  logic        p_valid;
  logic        p_ready;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic [31:0] p_pc;

  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  logic [31:0] s_pc;

  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_wa;

  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic        hazard;

  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  modport master (
    output p_valid, p_wa, p_wd, p_pc,
    input  p_ready,
    output s_valid, s_wa, s_wd, s_pc,
    input  s_ready,
    output iss_valid, iss_wa,
    input  iss_ready,
    output chk_a1, chk_a2,
    input  hazard,
    input  grf_we, grf_wa, grf_wd, grf_pc
  );

  modport slave (
    input  p_valid, p_wa, p_wd, p_pc,
    output p_ready,
    input  s_valid, s_wa, s_wd, s_pc,
    output s_ready,
    input  iss_valid, iss_wa,
    output iss_ready,
    input  chk_a1, chk_a2,
    output hazard,
    output grf_we, grf_wa, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write port arbiter with secondary FIFO and pending scoreboard (trace: GRF_WB_TRACE_EN)
module grf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [3:0]  SLIM = 4'(STARVE_LIMIT);

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [3:0]    starve;
  logic [1:0]    cnt [32];

  logic          nonempty;
  logic          sel_s;
  logic          push;
  logic          commit;
  logic          inc;
  logic          dec;
  logic [4:0]    head_wa;
  logic [4:0]    out_wa;
  logic [31:0]   inc_vec;
  logic [31:0]   dec_vec;

  // Grant is combinational; the head is forced through once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    nonempty      = (count != '0);
    head_wa       = fifo_wa[rd_ptr];
    sel_s         = !reset && nonempty && (!bus.p_valid || (starve == SLIM));
    bus.p_ready   = !reset && !sel_s;
    bus.s_ready   = !reset && (count != FULL);
    push          = bus.s_valid && bus.s_ready;
    commit        = sel_s || (bus.p_valid && bus.p_ready);
    out_wa        = sel_s ? head_wa : bus.p_wa;
    bus.grf_wa    = out_wa;
    bus.grf_wd    = sel_s ? fifo_wd[rd_ptr] : bus.p_wd;
    bus.grf_pc    = sel_s ? fifo_pc[rd_ptr] : bus.p_pc;
    bus.grf_we    = commit && (out_wa != 5'd0);
    bus.iss_ready = !reset && ((cnt[bus.iss_wa] != 2'd3) || (bus.iss_wa == 5'd0));
    bus.hazard    = !reset && ((cnt[bus.chk_a1] != 2'd0) || (cnt[bus.chk_a2] != 2'd0));
    inc           = bus.iss_valid && bus.iss_ready && (bus.iss_wa != 5'd0);
    dec           = sel_s && (head_wa != 5'd0);
  end

  // One-hot increment/decrement selects; register 0 is never tracked.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[bus.iss_wa] = 1'b1;
    if (dec) dec_vec[head_wa] = 1'b1;
    inc_vec[0] = 1'b0;
    dec_vec[0] = 1'b0;
  end

  // FIFO payload storage; entries are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= bus.s_wa;
      fifo_wd[wr_ptr] <= bus.s_wd;
      fifo_pc[wr_ptr] <= bus.s_pc;
    end
  end

  // FIFO pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (sel_s) rd_ptr <= rd_ptr + AW'(1);
      if (push && !sel_s)      count <= count + (AW + 1)'(1);
      else if (!push && sel_s) count <= count - (AW + 1)'(1);
    end
  end

  // Starvation counter: counts consecutive primary wins over a waiting head.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= 4'd0;
    end else if (sel_s || !nonempty) begin
      starve <= 4'd0;
    end else if (bus.p_valid && (starve != SLIM)) begin
      starve <= starve + 4'd1;
    end
  end

  // Pending scoreboard: simultaneous inc/dec on one register cancel; decrement at zero holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + 2'd1;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0)) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Commit trace and scoreboard underflow report.
  always_ff @(posedge clk) begin
    if (bus.grf_we) begin
      $display("@%08h: $%d <= %08h", bus.grf_pc, bus.grf_wa, bus.grf_wd);
    end
    if (!reset && dec && !inc_vec[head_wa] && (cnt[head_wa] == 2'd0)) begin
      $display("ERROR: scoreboard decrement at zero on $%0d", head_wa);
    end
  end
`else
`endif

endmodule
